// File: rtl/multicycle_controller.sv
// Multicycle RV32I main control FSM driving datapath muxes, ALU op and memory strobes.
// Latency: R/I/store 4 cycles, load 5, BEQ 3 with zero wait states; each wait state adds one.
// Backpressure: holds FETCH/MEM_RD/MEM_WR until mem_ready, traps after MEM_TIMEOUT idle cycles.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       alu_zero,
    output logic       i_mem_req,
    output logic       d_mem_read,
    output logic       d_mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic       mem_fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_MEM   = 4'd7,
        WB_ALU   = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           cur, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ill_r, flt_r;
    logic             set_ill, set_flt;
    logic             waiting, timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur   <= FETCH;
            cnt   <= '0;
            ill_r <= 1'b0;
            flt_r <= 1'b0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
            if (set_ill) ill_r <= 1'b1;
            if (set_flt) flt_r <= 1'b1;
        end
    end

    always_comb begin
        nxt         = cur;
        set_ill     = 1'b0;
        set_flt     = 1'b0;
        i_mem_req   = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        alu_op      = 2'b00;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        waiting     = (cur == FETCH) || (cur == MEM_RD) || (cur == MEM_WR);
        // a completing handshake on the last allowed cycle beats the timeout
        timeout     = waiting && !mem_ready && (cnt == CNT_LAST);

        case (cur)
            FETCH: begin
                i_mem_req = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end else if (timeout) begin
                    nxt     = TRAP;
                    set_flt = 1'b1;
                end
            end
            DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                alu_op    = 2'b01;
                case (opcode)
                    OP_R:              nxt = EXEC_R;
                    OP_I:              nxt = EXEC_I;
                    OP_LOAD, OP_STORE: nxt = MEM_ADDR;
                    OP_BEQ:            nxt = BRANCH;
                    default: begin
                        nxt     = TRAP;
                        set_ill = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd0;
                alu_op    = 2'b10;
                nxt       = WB_ALU;
            end
            EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                alu_op    = 2'b00;
                nxt       = WB_ALU;
            end
            MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                alu_op    = 2'b01;
                nxt       = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                d_mem_read = 1'b1;
                if (mem_ready) begin
                    nxt = WB_MEM;
                end else if (timeout) begin
                    nxt     = TRAP;
                    set_flt = 1'b1;
                end
            end
            MEM_WR: begin
                d_mem_write = 1'b1;
                if (mem_ready) begin
                    nxt = FETCH;
                end else if (timeout) begin
                    nxt     = TRAP;
                    set_flt = 1'b1;
                end
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = FETCH;
            end
            WB_ALU: begin
                reg_write = 1'b1;
                nxt       = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd0;
                alu_op    = 2'b11;
                pc_src    = 1'b1;
                pc_write  = alu_zero;
                nxt       = FETCH;
            end
            TRAP:    nxt = TRAP;
            default: nxt = TRAP;
        endcase

        if (nxt != cur)
            cnt_nxt = '0;
        else if (waiting && !mem_ready)
            cnt_nxt = cnt + CNT_W'(1);
        else
            cnt_nxt = cnt;

        // strobes stay quiet while reset is held, even with mem_ready high in FETCH
        if (rst) begin
            i_mem_req   = 1'b0;
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 1'b0;
            alu_src_a   = 2'd0;
            alu_src_b   = 2'd0;
            alu_op      = 2'b00;
            mem_to_reg  = 1'b0;
            reg_write   = 1'b0;
        end
    end

    assign illegal_op = ill_r;
    assign mem_fault  = flt_r;
    assign state      = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: instruction-level reference model expands each instruction into its
// expected per-cycle state/strobe trace and compares against the controller every cycle.
module tb_multicycle_controller;

    localparam int TMO = 16;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready, alu_zero;
    logic       i_mem_req, d_mem_read, d_mem_write, ir_write, pc_write, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       mem_to_reg, reg_write, illegal_op, mem_fault;
    logic [3:0] state;
    logic [15:0] obs;

    int compared   = 0;
    int mismatched = 0;

    logic ill_m, flt_m;
    bit   trapped;

    multicycle_controller #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .i_mem_req(i_mem_req), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_op(illegal_op), .mem_fault(mem_fault), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {i_mem_req, d_mem_read, d_mem_write, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write, illegal_op, mem_fault};

    function automatic logic [15:0] o(input logic imr, dr, dw, irw, pcw, pcs,
                                      input logic [1:0] sa, sb, aop, input logic m2r, rw);
        return {imr, dr, dw, irw, pcw, pcs, sa, sb, aop, m2r, rw, ill_m, flt_m};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    // one clock cycle: apply inputs just after the edge, compare mid-cycle
    task automatic cyc(input string tag, input logic [6:0] op, input logic rdy, input logic zero,
                       input logic [3:0] est, input logic [15:0] eout);
        opcode    = op;
        mem_ready = rdy;
        alu_zero  = zero;
        @(negedge clk);
        compared++;
        assert ({state, obs} === {est, eout}) else begin
            mismatched++;
            $error("FAIL %s: observed state=%0d outs=%h, expected state=%0d outs=%h",
                   tag, state, obs, est, eout);
        end
        @(posedge clk);
        #1;
    endtask

    // nwait idle cycles then a ready cycle; the TMO-th idle cycle ends in a fault
    task automatic wait_phase(input string tag, input logic [3:0] st, input int nwait,
                              input logic [15:0] busy, input logic [15:0] done, output bit to);
        to = 1'b0;
        for (int i = 0; i < nwait; i++) begin
            cyc(tag, rop(), 1'b0, rb(), st, busy);
            if (i == TMO - 1) begin
                flt_m = 1'b1;
                to    = 1'b1;
                return;
            end
        end
        cyc(tag, rop(), 1'b1, rb(), st, done);
    endtask

    task automatic instr(input logic [6:0] op, input int fw, input int mw, input logic zero);
        bit to;
        wait_phase("fetch", 4'd0, fw, o(1,0,0,0,0,0,2'd0,2'd1,2'b01,0,0),
                   o(1,0,0,1,1,0,2'd0,2'd1,2'b01,0,0), to);
        if (to) begin
            trapped = 1'b1;
            return;
        end
        cyc("decode", op, rb(), rb(), 4'd1, o(0,0,0,0,0,0,2'd2,2'd2,2'b01,0,0));
        case (op)
            OP_R: begin
                cyc("exec_r", rop(), rb(), rb(), 4'd2, o(0,0,0,0,0,0,2'd1,2'd0,2'b10,0,0));
                cyc("wb_alu", rop(), rb(), rb(), 4'd8, o(0,0,0,0,0,0,2'd0,2'd0,2'b00,0,1));
            end
            OP_I: begin
                cyc("exec_i", rop(), rb(), rb(), 4'd3, o(0,0,0,0,0,0,2'd1,2'd2,2'b00,0,0));
                cyc("wb_alu", rop(), rb(), rb(), 4'd8, o(0,0,0,0,0,0,2'd0,2'd0,2'b00,0,1));
            end
            OP_LOAD, OP_STORE: begin
                cyc("mem_addr", op, rb(), rb(), 4'd4, o(0,0,0,0,0,0,2'd1,2'd2,2'b01,0,0));
                if (op == OP_LOAD) begin
                    wait_phase("mem_rd", 4'd5, mw, o(0,1,0,0,0,0,2'd0,2'd0,2'b00,0,0),
                               o(0,1,0,0,0,0,2'd0,2'd0,2'b00,0,0), to);
                    if (to) begin
                        trapped = 1'b1;
                        return;
                    end
                    cyc("wb_mem", rop(), rb(), rb(), 4'd7, o(0,0,0,0,0,0,2'd0,2'd0,2'b00,1,1));
                end else begin
                    wait_phase("mem_wr", 4'd6, mw, o(0,0,1,0,0,0,2'd0,2'd0,2'b00,0,0),
                               o(0,0,1,0,0,0,2'd0,2'd0,2'b00,0,0), to);
                    if (to) trapped = 1'b1;
                end
            end
            OP_BEQ: cyc("branch", rop(), rb(), zero, 4'd9, o(0,0,0,0,zero,1,2'd1,2'd0,2'b11,0,0));
            default: begin
                ill_m   = 1'b1;
                trapped = 1'b1;
            end
        endcase
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++)
            cyc("trap", rop(), rb(), rb(), 4'd10, o(0,0,0,0,0,0,2'd0,2'd0,2'b00,0,0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = rop();
        @(posedge clk);
        #1;
        ill_m   = 1'b0;
        flt_m   = 1'b0;
        trapped = 1'b0;
        cyc("reset", rop(), 1'b1, rb(), 4'd0, 16'h0000);
        cyc("reset", rop(), 1'b1, rb(), 4'd0, 16'h0000);
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] ops [6];
        rst = 1'b1;
        opcode = 7'd0;
        mem_ready = 1'b1;
        alu_zero = 1'b0;
        ill_m = 1'b0;
        flt_m = 1'b0;
        trapped = 1'b0;
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LOAD;
        ops[3] = OP_STORE; ops[4] = OP_BEQ; ops[5] = 7'b1111111;

        do_reset();
        instr(OP_R, 0, 0, 1'b0);
        instr(OP_LOAD, 0, 3, 1'b0);
        instr(OP_STORE, 1, 2, 1'b0);
        instr(OP_I, 0, 0, 1'b0);
        instr(OP_BEQ, 0, 0, 1'b1);
        instr(OP_BEQ, 2, 0, 1'b0);
        instr(OP_R, TMO - 1, 0, 1'b0);
        instr(OP_LOAD, 0, TMO - 1, 1'b0);
        instr(OP_STORE, 0, TMO - 1, 1'b0);

        instr(7'b1111111, 0, 0, 1'b0);
        trap_hold(20);
        do_reset();

        instr(OP_R, TMO, 0, 1'b0);
        trap_hold(5);
        do_reset();

        instr(OP_LOAD, 0, TMO, 1'b0);
        trap_hold(3);
        do_reset();

        instr(OP_STORE, 0, TMO, 1'b0);
        trap_hold(3);
        do_reset();

        // reset mid-wait must clear the wait counter
        for (int i = 0; i < 7; i++)
            cyc("fetch_wait", rop(), 1'b0, rb(), 4'd0, o(1,0,0,0,0,0,2'd0,2'd1,2'b01,0,0));
        do_reset();
        instr(OP_R, TMO - 1, 0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            logic [6:0] op;
            int fw, mw;
            op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) op = rop();
            fw = ($urandom_range(0, 24) == 0) ? TMO : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 24) == 0) ? TMO : int'($urandom_range(0, 3));
            instr(op, fw, mw, rb());
            if (trapped) begin
                trap_hold(int'($urandom_range(1, 4)));
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
